// File: rtl/delay_line_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// delay_line_ctrl_pkg
// Shared types and defaults for the programmable delay line controller.
//   state_t       : controller FSM states (RUN, DRAIN, SWITCH)
//   MAX_DELAY_DEF : default maximum programmable delay, in cycles
//   DLY_W_DEF     : default width of a delay setting
//   DLY_RESET     : delay in force after reset
// ---------------------------------------------------------------------------
package delay_line_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam int MAX_DELAY_DEF = 3;
  localparam int DLY_W_DEF     = 2;
  localparam int DLY_RESET     = 1;

endpackage

// File: rtl/delay_line_ctrl_vstage.sv
// ---------------------------------------------------------------------------
// delay_vstage
// One {valid, data} register stage of the delay line.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low clear of valid and data
//   clr       : synchronous clear of the valid bit (data is left alone)
//   in_valid  : incoming valid; data is loaded only while this is high
//   in_data   : incoming data word
//   out_valid : registered valid
//   out_data  : registered data (held while no valid beat arrives)
// ---------------------------------------------------------------------------
module delay_vstage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= in_valid & ~clr;
      // Holding data on bubbles keeps the data path quiet; only valid moves.
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// delay_line_ctrl
// Runtime-programmable fixed-latency delay line. A valid-qualified stream is
// carried through MAX_DELAY register stages and tapped at stage
// (cur_delay-1). A delay change is applied only after the taps in use have
// drained, so no beat is lost, duplicated or reordered.
//
// Ports:
//   clk, reset           : clock / asynchronous active-low reset
//   in_valid, in_data    : input beat; accepted when in_ready is high
//   in_ready             : high in RUN (and never while reset is asserted)
//   out_valid, out_data  : output beat strobe, no backpressure
//   cfg_req, cfg_delay   : delay change request (held until ack or err)
//   cfg_ack, cfg_err     : one-cycle result pulses
//   cur_delay            : delay currently in force
//   busy                 : high while draining or switching
//
// Optional build macro DELAY_LINE_CTRL_STAT_EN adds:
//   beat_cnt   [15:0]    : saturating count of out_valid beats
//   reconf_cnt [7:0]     : wrapping count of cfg_ack pulses
// ---------------------------------------------------------------------------
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DELAY  = MAX_DELAY_DEF,
  parameter int DLY_W      = DLY_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  cfg_req,
  input  logic [DLY_W-1:0]      cfg_delay,
  output logic                  cfg_ack,
  output logic                  cfg_err,
  output logic [DLY_W-1:0]      cur_delay,
  output logic                  busy
`ifdef DELAY_LINE_CTRL_STAT_EN
  ,
  output logic [15:0]           beat_cnt,
  output logic [7:0]            reconf_cnt
`endif
);

  state_t               state_reg;
  logic [DLY_W-1:0]     cur_delay_reg;
  logic [DLY_W-1:0]     pend_delay_reg;
  logic                 cfg_ack_reg;
  logic                 cfg_err_reg;

  logic [MAX_DELAY-1:0] stage_valid;
  logic [DATA_WIDTH-1:0] stage_data [MAX_DELAY];
  logic [MAX_DELAY-1:0] stage_in_valid;
  logic [DATA_WIDTH-1:0] stage_in_data [MAX_DELAY];

  logic                 accept;
  logic                 stage_clr;
  logic                 window_busy;
  logic                 cfg_take;
  logic                 cfg_bad;

  // Gating with reset keeps in_ready low for the whole reset assertion even
  // though the state register already reads RUN.
  assign in_ready  = reset & (state_reg == RUN);
  assign busy      = (state_reg != RUN);
  assign accept    = in_valid & in_ready;
  assign stage_clr = (state_reg == SWITCH);
  assign cfg_ack   = cfg_ack_reg;
  assign cfg_err   = cfg_err_reg;
  assign cur_delay = cur_delay_reg;

  // A requester still holds cfg_req during the result pulse; ignoring it for
  // that cycle keeps results from repeating back to back.
  assign cfg_take = cfg_req & ~cfg_ack_reg & ~cfg_err_reg;
  assign cfg_bad  = (cfg_delay == '0) || (int'(cfg_delay) > MAX_DELAY);

  // ---------------------------------------------------------------- stages
  generate
    for (genvar gi = 0; gi < MAX_DELAY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_in_valid[gi] = accept;
        assign stage_in_data[gi]  = in_data;
      end else begin : g_body
        assign stage_in_valid[gi] = stage_valid[gi-1];
        assign stage_in_data[gi]  = stage_data[gi-1];
      end

      delay_vstage #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .clr      (stage_clr),
        .in_valid (stage_in_valid[gi]),
        .in_data  (stage_in_data[gi]),
        .out_valid(stage_valid[gi]),
        .out_data (stage_data[gi])
      );
    end
  endgenerate

  // Only stages 0..cur_delay-1 can still produce an output; deeper stages
  // hold beats that already exited and are wiped in SWITCH.
  always_comb begin
    window_busy = 1'b0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if ((k < int'(cur_delay_reg)) && stage_valid[k]) begin
        window_busy = 1'b1;
      end
    end
  end

  // Output tap at stage cur_delay-1.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (cur_delay_reg == DLY_W'(k + 1)) begin
        out_valid = stage_valid[k];
        out_data  = stage_data[k];
      end
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= RUN;
      cur_delay_reg  <= DLY_W'(DLY_RESET);
      pend_delay_reg <= DLY_W'(DLY_RESET);
      cfg_ack_reg    <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      cfg_ack_reg <= 1'b0;
      cfg_err_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (cfg_take) begin
            if (cfg_bad) begin
              cfg_err_reg <= 1'b1;
            end else if (cfg_delay == cur_delay_reg) begin
              cfg_ack_reg <= 1'b1;
            end else begin
              pend_delay_reg <= cfg_delay;
              state_reg      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!window_busy) begin
            state_reg <= SWITCH;
          end
        end
        SWITCH: begin
          cur_delay_reg <= pend_delay_reg;
          cfg_ack_reg   <= 1'b1;
          state_reg     <= RUN;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

`ifdef DELAY_LINE_CTRL_STAT_EN
  logic [15:0] beat_cnt_reg;
  logic [7:0]  reconf_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_reg   <= '0;
      reconf_cnt_reg <= '0;
    end else begin
      if (out_valid && (beat_cnt_reg != 16'hFFFF)) begin
        beat_cnt_reg <= beat_cnt_reg + 16'd1;
      end
      if (cfg_ack_reg) begin
        reconf_cnt_reg <= reconf_cnt_reg + 8'd1;
      end
    end
  end

  assign beat_cnt   = beat_cnt_reg;
  assign reconf_cnt = reconf_cnt_reg;
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_delay_line_ctrl
// Self-checking bench for delay_line_ctrl. A timestamp reference model
// predicts every output: each accepted beat is due exactly cur_delay cycles
// after acceptance, a reconfiguration drains once no due time is still
// pending, then takes one switch cycle. Build with DELAY_LINE_CTRL_STAT_EN
// to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_delay_line_ctrl;

  localparam int DW = 8;
  localparam int MD = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          cfg_req = 1'b0;
  logic [1:0]    cfg_delay = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          cfg_ack;
  logic          cfg_err;
  logic [1:0]    cur_delay;
  logic          busy;
`ifdef DELAY_LINE_CTRL_STAT_EN
  logic [15:0]   beat_cnt;
  logic [7:0]    reconf_cnt;
`endif

  always #5 clk = ~clk;

  delay_line_ctrl #(
    .DATA_WIDTH(DW),
    .MAX_DELAY (MD),
    .DLY_W     (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .cfg_req  (cfg_req),
    .cfg_delay(cfg_delay),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .cur_delay(cur_delay),
    .busy     (busy)
`ifdef DELAY_LINE_CTRL_STAT_EN
    ,
    .beat_cnt  (beat_cnt),
    .reconf_cnt(reconf_cnt)
`endif
  );

  // ------------------------------------------------------------ checking
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ----------------------------------------------------- reference model
  typedef struct {
    int            t;
    logic [DW-1:0] d;
  } beat_t;

  beat_t      exp_q[$];
  int         m_mode;      // 0 run, 1 drain, 2 switch
  int         m_cur;
  int         m_pend;
  int         last_exit;
  bit         m_ack;
  bit         m_err;
  int         m_beats;
  int         m_reconf;
  bit         req_active;
  logic [1:0] req_dly;

  task automatic model_reset();
    exp_q.delete();
    m_mode     = 0;
    m_cur      = 1;
    m_pend     = 1;
    last_exit  = -1;
    m_ack      = 1'b0;
    m_err      = 1'b0;
    m_beats    = 0;
    m_reconf   = 0;
    req_active = 1'b0;
    req_dly    = '0;
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, advance
  // the model across the rising edge, return at the next falling edge.
  task automatic tick(input bit v, input logic [DW-1:0] d);
    bit            exp_rdy;
    bit            exp_ov;
    bit            nack;
    bit            nerr;
    int            dly_i;
    in_valid  = v;
    in_data   = d;
    cfg_req   = req_active;
    cfg_delay = req_dly;
    #1;
    exp_rdy = (m_mode == 0);
    exp_ov  = (exp_q.size() > 0) && (exp_q[0].t == cyc);
    check_val("in_ready",  32'(in_ready),  32'(exp_rdy));
    check_val("busy",      32'(busy),      32'(m_mode != 0));
    check_val("cfg_ack",   32'(cfg_ack),   32'(m_ack));
    check_val("cfg_err",   32'(cfg_err),   32'(m_err));
    check_val("cur_delay", 32'(cur_delay), 32'(m_cur));
    check_val("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check_val("out_data", 32'(out_data), 32'(exp_q[0].d));
      void'(exp_q.pop_front());
      m_beats++;
    end
    if (m_ack) m_reconf++;
    if ((m_ack || m_err) && req_active) begin
      $display("cfg delay=%0d -> %s, cur_delay=%0d (cycle %0d)",
               req_dly, m_ack ? "ack" : "err", m_cur, cyc);
      req_active = 1'b0;
    end
    if (v && exp_rdy) begin
      exp_q.push_back('{cyc + m_cur, d});
      last_exit = cyc + m_cur;
    end
    nack  = 1'b0;
    nerr  = 1'b0;
    dly_i = int'(cfg_delay);
    case (m_mode)
      0: begin
        if (cfg_req && !m_ack && !m_err) begin
          if (dly_i == 0 || dly_i > MD) nerr = 1'b1;
          else if (dly_i == m_cur) nack = 1'b1;
          else begin
            m_pend = dly_i;
            m_mode = 1;
          end
        end
      end
      1: begin
        if (last_exit < cyc) m_mode = 2;
      end
      default: begin
        m_mode = 0;
        m_cur  = m_pend;
        nack   = 1'b1;
      end
    endcase
    m_ack = nack;
    m_err = nerr;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom));
  endtask

  task automatic start_req(input logic [1:0] dly);
    req_active = 1'b1;
    req_dly    = dly;
  endtask

  task automatic wait_req();
    int budget;
    budget = 0;
    while (req_active && budget < 40) begin
      tick(1'b0, 8'($urandom));
      budget++;
    end
    check_val("cfg_done", 32'(req_active), 32'd0);
    req_active = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_out_data"},  32'(out_data),  32'd0);
    check_val({tag, "_cfg_ack"},   32'(cfg_ack),   32'd0);
    check_val({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
    check_val({tag, "_busy"},      32'(busy),      32'd0);
    check_val({tag, "_cur_delay"}, 32'(cur_delay), 32'd1);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // Delay 1 basic stream.
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    tick(1'b1, 8'h33);
    idle(3);

    // 1 -> 3 with beats in flight; request raised with the last beat.
    tick(1'b1, 8'hA0);
    tick(1'b1, 8'hA1);
    tick(1'b1, 8'hA2);
    start_req(2'd3);
    tick(1'b1, 8'hA3);
    wait_req();
    tick(1'b1, 8'hB0);
    idle(4);

    // 3 -> 2, then an invalid delay, then a same-delay request.
    start_req(2'd2);
    wait_req();
    start_req(2'd0);
    wait_req();
    start_req(2'd2);
    wait_req();
    idle(2);

    // Continuous stream across a 1 -> 2 change.
    start_req(2'd1);
    wait_req();
    for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h40 + i));
    start_req(2'd2);
    for (int i = 6; i < 24; i++) tick(1'b1, 8'(8'h40 + i));
    idle(4);

    // Reset asserted while draining.
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'hC0 + i));
    start_req(2'd3);
    tick(1'b1, 8'hC3);
    tick(1'b0, 8'h00);
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    cfg_req  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    reset = 1'b1;
    model_reset();
    idle(3);

    // Randomized traffic and requests.
    for (int i = 0; i < 400; i++) begin
      if (!req_active && !m_ack && !m_err && $urandom_range(0, 15) == 0) begin
        start_req(2'($urandom_range(0, 3)));
      end
      tick(1'($urandom_range(0, 1)), 8'($urandom));
    end
    idle(5);

`ifdef DELAY_LINE_CTRL_STAT_EN
    check_val("beat_cnt",   32'(beat_cnt),   32'(m_beats));
    check_val("reconf_cnt", 32'(reconf_cnt), 32'(m_reconf % 256));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
